axi_crossbar_addr_ctrl: RTL and testbench

Per-slave-port address decode and admission control for the AXI crossbar. It adds per-master outstanding limits (M_ISSUE) to the existing ID-thread ordering and total-accept limits, plus an explicit stall indication. It sits between each slave-port AW/AR register slice and the crossbar arbiters. It also emits write-command and reply-command tokens for the W and B/R paths.

---
 rtl/axi_crossbar_addr_ctrl_if.sv | 45 ++++
 rtl/axi_crossbar_addr_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi_crossbar_addr_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_crossbar_addr_ctrl_if.sv
// Address request, forwarded command, write/reply command tokens and completion
// signals of one crossbar slave port, grouped for axi_crossbar_addr_ctrl.
interface axi_crossbar_addr_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned M_COUNT    = 4
);
   localparam int unsigned SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

   logic [ID_WIDTH-1:0]   s_axi_aid;
   logic [ADDR_WIDTH-1:0] s_axi_aaddr;
   logic [2:0]            s_axi_aprot;
   logic                  s_axi_avalid;
   logic                  s_axi_aready;
   logic [3:0]            m_axi_aregion;
   logic [SEL_W-1:0]      m_select;
   logic                  m_axi_avalid;
   logic                  m_axi_aready;
   logic [SEL_W-1:0]      m_wc_select;
   logic                  m_wc_decerr;
   logic                  m_wc_valid;
   logic                  m_wc_ready;
   logic                  m_rc_decerr;
   logic                  m_rc_valid;
   logic                  m_rc_ready;
   logic [ID_WIDTH-1:0]   s_cpl_id;
   logic                  s_cpl_valid;
   logic                  stall;

   // Address controller side
   modport slave (
      input  s_axi_aid, s_axi_aaddr, s_axi_aprot, s_axi_avalid,
      input  m_axi_aready, m_wc_ready, m_rc_ready, s_cpl_id, s_cpl_valid,
      output s_axi_aready, m_axi_aregion, m_select, m_axi_avalid,
      output m_wc_select, m_wc_decerr, m_wc_valid, m_rc_decerr, m_rc_valid, stall
   );

   // Register slice, arbiters and W/B/R paths surrounding the controller
   modport master (
      output s_axi_aid, s_axi_aaddr, s_axi_aprot, s_axi_avalid,
      output m_axi_aready, m_wc_ready, m_rc_ready, s_cpl_id, s_cpl_valid,
      input  s_axi_aready, m_axi_aregion, m_select, m_axi_avalid,
      input  m_wc_select, m_wc_decerr, m_wc_valid, m_rc_decerr, m_rc_valid, stall
   );
endinterface

// File: rtl/axi_crossbar_addr_ctrl.sv
// Per-slave-port address decode and admission control (thread ordering, total and per-master limits).
// Optional AXI_XBAR_ADDR_DECERR_CNT_EN adds a saturating decode-error counter output.
module axi_crossbar_addr_ctrl #(
   parameter int unsigned S          = 0,
   parameter int unsigned S_COUNT    = 4,
   parameter int unsigned M_COUNT    = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned S_THREADS  = 2,
   parameter int unsigned S_ACCEPT   = 16,
   parameter int unsigned M_REGIONS  = 1,
   parameter logic [M_COUNT*M_REGIONS*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
   parameter logic [M_COUNT*M_REGIONS*32-1:0] M_ADDR_WIDTH = {M_COUNT{{M_REGIONS{32'd24}}}},
   parameter logic [M_COUNT*S_COUNT-1:0] M_CONNECT = {M_COUNT{{S_COUNT{1'b1}}}},
   parameter logic [M_COUNT-1:0] M_SECURE = '0,
   parameter logic [M_COUNT*32-1:0] M_ISSUE = {M_COUNT{32'd4}},
   parameter bit WC_OUTPUT = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   axi_crossbar_addr_ctrl_if.slave bus
`ifdef AXI_XBAR_ADDR_DECERR_CNT_EN
   , output logic [15:0] decerr_count
`endif
);
   localparam int unsigned SEL_W   = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
   localparam int unsigned THREADS = (S_THREADS < S_ACCEPT) ? S_THREADS : S_ACCEPT;
   localparam int unsigned THR_W   = (THREADS > 1) ? $clog2(THREADS) : 1;
   localparam int unsigned CNT_W   = $clog2(S_ACCEPT + 1);
   localparam int unsigned NREG    = M_COUNT * M_REGIONS;

   // Packed default map: each used region aligned to its size, ascending from 0
   function automatic logic [NREG*ADDR_WIDTH-1:0] default_map();
      logic [NREG*ADDR_WIDTH-1:0] res;
      logic [ADDR_WIDTH-1:0] base, mask, size;
      int unsigned w;
      res  = '0;
      base = '0;
      for (int i = 0; i < int'(NREG); i++) begin
         w    = M_ADDR_WIDTH[i*32 +: 32];
         mask = (w >= ADDR_WIDTH) ? '1 : ((ADDR_WIDTH'(1) << w) - ADDR_WIDTH'(1));
         size = mask + ADDR_WIDTH'(1);
         if (w != 0) begin
            if ((base & mask) != '0) base = base + size - (base & mask);
            res[i*ADDR_WIDTH +: ADDR_WIDTH] = base;
            base = base + size;
         end
      end
      return res;
   endfunction

   localparam logic [NREG*ADDR_WIDTH-1:0] BASE_ADDR = (M_BASE_ADDR == '0) ? default_map() : M_BASE_ADDR;

   function automatic logic region_hit(input logic [ADDR_WIDTH-1:0] addr, input logic prot_ns,
                                       input int unsigned m, input int unsigned r);
      int unsigned idx, w;
      idx = m * M_REGIONS + r;
      w   = M_ADDR_WIDTH[idx*32 +: 32];
      return (w != 0) && M_CONNECT[m*S_COUNT + S] && !(M_SECURE[m] && prot_ns) &&
             ((addr >> w) == (BASE_ADDR[idx*ADDR_WIDTH +: ADDR_WIDTH] >> w));
   endfunction

   typedef enum logic {IDLE, DECODE} state_t;

   state_t              state;
   logic                avalid_q, wc_valid_q, rc_valid_q, aready_q, stall_q, decerr_q;
   logic [SEL_W-1:0]    sel_q;
   logic [3:0]          region_q;
   logic [CNT_W-1:0]    total_cnt;
   logic [CNT_W-1:0]    issue_cnt [M_COUNT];
   logic [CNT_W-1:0]    thr_cnt   [THREADS];
   logic [ID_WIDTH-1:0] thr_id    [THREADS];
   logic [SEL_W-1:0]    thr_m     [THREADS];
   logic [3:0]          thr_r     [THREADS];

   logic                hit_c, cpl_hit_c, id_match_c, free_found_c, thr_ok_c;
   logic                issue_ok_c, total_ok_c, admit_c, req_c, trans_start_c;
   logic                avalid_nxt_c, wc_nxt_c, rc_nxt_c;
   logic [SEL_W-1:0]    sel_c;
   logic [3:0]          region_c;
   logic [THR_W-1:0]    cpl_thr_c, match_thr_c, free_thr_c, start_thr_c;
   logic                unused_prot_c;

   assign unused_prot_c = ^{bus.s_axi_aprot[2], bus.s_axi_aprot[0]};

   // Address decode: lowest (master, region) hit wins
   always_comb begin
      hit_c    = 1'b0;
      sel_c    = '0;
      region_c = '0;
      for (int m = 0; m < int'(M_COUNT); m++) begin
         for (int r = 0; r < int'(M_REGIONS); r++) begin
            if (!hit_c && region_hit(bus.s_axi_aaddr, bus.s_axi_aprot[1], m, r)) begin
               hit_c    = 1'b1;
               sel_c    = SEL_W'(m);
               region_c = 4'(r);
            end
         end
      end
   end

   // Completion lookup and thread match/allocation
   always_comb begin
      cpl_hit_c    = 1'b0;
      cpl_thr_c    = '0;
      id_match_c   = 1'b0;
      match_thr_c  = '0;
      free_found_c = 1'b0;
      free_thr_c   = '0;
      for (int t = 0; t < int'(THREADS); t++) begin
         if (!cpl_hit_c && bus.s_cpl_valid && thr_cnt[t] != '0 && thr_id[t] == bus.s_cpl_id) begin
            cpl_hit_c = 1'b1;
            cpl_thr_c = THR_W'(t);
         end
         if (thr_cnt[t] != '0 && thr_id[t] == bus.s_axi_aid) begin
            id_match_c  = 1'b1;
            match_thr_c = THR_W'(t);
         end
         if (!free_found_c && thr_cnt[t] == '0) begin
            free_found_c = 1'b1;
            free_thr_c   = THR_W'(t);
         end
      end
      // An ID already in flight elsewhere must wait to keep responses ordered
      thr_ok_c    = id_match_c ? (thr_m[match_thr_c] == sel_c && thr_r[match_thr_c] == region_c)
                               : free_found_c;
      start_thr_c = id_match_c ? match_thr_c : free_thr_c;
   end

   always_comb begin
      issue_ok_c = 1'b0;
      for (int m = 0; m < int'(M_COUNT); m++) begin
         if (sel_c == SEL_W'(m))
            issue_ok_c = (32'(issue_cnt[m]) < M_ISSUE[m*32 +: 32]) ||
                         (cpl_hit_c && thr_m[cpl_thr_c] == sel_c);
      end
      total_ok_c    = (32'(total_cnt) < S_ACCEPT) || cpl_hit_c;
      admit_c       = total_ok_c && issue_ok_c && thr_ok_c;
      req_c         = (state == IDLE) && bus.s_axi_avalid && !aready_q;
      trans_start_c = req_c && hit_c && admit_c;
      avalid_nxt_c  = avalid_q && !bus.m_axi_aready;
      wc_nxt_c      = wc_valid_q && !bus.m_wc_ready;
      rc_nxt_c      = rc_valid_q && !bus.m_rc_ready;
   end

   // Request FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         avalid_q   <= 1'b0;
         wc_valid_q <= 1'b0;
         rc_valid_q <= 1'b0;
         aready_q   <= 1'b0;
         stall_q    <= 1'b0;
         decerr_q   <= 1'b0;
         sel_q      <= '0;
         region_q   <= '0;
      end else begin
         aready_q <= 1'b0;
         stall_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (trans_start_c) begin
                  avalid_q   <= 1'b1;
                  wc_valid_q <= WC_OUTPUT;
                  rc_valid_q <= 1'b0;
                  decerr_q   <= 1'b0;
                  sel_q      <= sel_c;
                  region_q   <= region_c;
                  state      <= DECODE;
               end else if (req_c && hit_c) begin
                  stall_q <= 1'b1;
               end else if (req_c) begin
                  avalid_q   <= 1'b0;
                  wc_valid_q <= WC_OUTPUT;
                  rc_valid_q <= 1'b1;
                  decerr_q   <= 1'b1;
                  state      <= DECODE;
               end
            end
            DECODE: begin
               avalid_q   <= avalid_nxt_c;
               wc_valid_q <= wc_nxt_c;
               rc_valid_q <= rc_nxt_c;
               if (!avalid_nxt_c && !wc_nxt_c && !rc_nxt_c) begin
                  aready_q <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outstanding counters; a start and a completion on the same counter cancel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_cnt <= '0;
         for (int m = 0; m < int'(M_COUNT); m++) issue_cnt[m] <= '0;
         for (int t = 0; t < int'(THREADS); t++) begin
            thr_cnt[t] <= '0;
            thr_id[t]  <= '0;
            thr_m[t]   <= '0;
            thr_r[t]   <= '0;
         end
      end else begin
         total_cnt <= total_cnt + CNT_W'(trans_start_c) - CNT_W'(cpl_hit_c);
         for (int m = 0; m < int'(M_COUNT); m++)
            issue_cnt[m] <= issue_cnt[m] + CNT_W'(trans_start_c && sel_c == SEL_W'(m))
                                         - CNT_W'(cpl_hit_c && thr_m[cpl_thr_c] == SEL_W'(m));
         for (int t = 0; t < int'(THREADS); t++) begin
            thr_cnt[t] <= thr_cnt[t] + CNT_W'(trans_start_c && start_thr_c == THR_W'(t))
                                     - CNT_W'(cpl_hit_c && cpl_thr_c == THR_W'(t));
            if (trans_start_c && start_thr_c == THR_W'(t)) begin
               thr_id[t] <= bus.s_axi_aid;
               thr_m[t]  <= sel_c;
               thr_r[t]  <= region_c;
            end
         end
      end
   end

`ifdef AXI_XBAR_ADDR_DECERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         decerr_count <= '0;
      else if (req_c && !hit_c && decerr_count != 16'hFFFF)
         decerr_count <= decerr_count + 16'd1;
   end
`endif

   assign bus.s_axi_aready  = aready_q;
   assign bus.m_axi_aregion = region_q;
   assign bus.m_select      = sel_q;
   assign bus.m_axi_avalid  = avalid_q;
   assign bus.m_wc_select   = sel_q;
   assign bus.m_wc_decerr   = decerr_q;
   assign bus.m_wc_valid    = wc_valid_q;
   assign bus.m_rc_decerr   = decerr_q;
   assign bus.m_rc_valid    = rc_valid_q;
   assign bus.stall         = stall_q;
endmodule

// File: tb/tb_axi_crossbar_addr_ctrl.sv
// Scoreboard bench for axi_crossbar_addr_ctrl: directed requests push expected
// decode results, a negedge monitor checks each forwarded/reply command.
`timescale 1ns/1ps
module tb_axi_crossbar_addr_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi_crossbar_addr_ctrl_if #(.ADDR_WIDTH(32), .ID_WIDTH(8), .M_COUNT(4)) bus ();
`ifdef AXI_XBAR_ADDR_DECERR_CNT_EN
   logic [15:0] decerr_count;
`endif

   axi_crossbar_addr_ctrl #(
      .S(0), .S_COUNT(4), .M_COUNT(4), .ADDR_WIDTH(32), .ID_WIDTH(8),
      .S_THREADS(2), .S_ACCEPT(16), .M_REGIONS(1),
      .M_SECURE(4'b1000),
      .M_ISSUE({32'd4, 32'd4, 32'd4, 32'd2}),
      .WC_OUTPUT(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
`ifdef AXI_XBAR_ADDR_DECERR_CNT_EN
      , .decerr_count(decerr_count)
`endif
   );

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] region;
      logic       decerr;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_v = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endfunction

   function automatic exp_t mk(input logic [1:0] sel, input logic [3:0] region, input logic decerr);
      exp_t e;
      e.sel    = sel;
      e.region = region;
      e.decerr = decerr;
      return e;
   endfunction

   // Monitor: each new forward or reply command is compared with the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (bus.m_axi_avalid || bus.m_rc_valid) && !prev_v) begin
         check("scoreboard_nonempty", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("fwd_valid", bus.m_axi_avalid, !e.decerr);
            check("rc_valid", bus.m_rc_valid, e.decerr);
            check("rc_decerr", bus.m_rc_decerr, e.decerr);
            check("wc_valid", bus.m_wc_valid, 1);
            check("wc_decerr", bus.m_wc_decerr, e.decerr);
            if (!e.decerr) begin
               check("m_select", bus.m_select, e.sel);
               check("wc_select", bus.m_wc_select, e.sel);
               check("aregion", bus.m_axi_aregion, e.region);
            end
         end
      end
      prev_v = rst_n && (bus.m_axi_avalid || bus.m_rc_valid);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_req(input logic [7:0] id, input logic [31:0] addr, input logic [2:0] prot, input exp_t e);
      exp_q.push_back(e);
      bus.s_axi_aid    = id;
      bus.s_axi_aaddr  = addr;
      bus.s_axi_aprot  = prot;
      bus.s_axi_avalid = 1'b1;
   endtask

   task automatic wait_accept(input string name);
      int n = 0;
      while (!bus.s_axi_aready && n < 50) begin
         step(1);
         n++;
      end
      check(name, bus.s_axi_aready, 1);
      step(1);
      bus.s_axi_avalid = 1'b0;
   endtask

   task automatic do_req(input logic [7:0] id, input logic [31:0] addr, input logic [2:0] prot,
                         input exp_t e, input string name);
      start_req(id, addr, prot, e);
      wait_accept(name);
   endtask

   task automatic complete(input logic [7:0] id);
      bus.s_cpl_id    = id;
      bus.s_cpl_valid = 1'b1;
      step(1);
      bus.s_cpl_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      bus.s_axi_aid    = '0;
      bus.s_axi_aaddr  = '0;
      bus.s_axi_aprot  = '0;
      bus.s_axi_avalid = 1'b0;
      bus.m_axi_aready = 1'b1;
      bus.m_wc_ready   = 1'b1;
      bus.m_rc_ready   = 1'b1;
      bus.s_cpl_id     = '0;
      bus.s_cpl_valid  = 1'b0;
      step(3);
      @(negedge clk) rst_n = 1'b1;
      step(2);

      // Reset state
      check("rst_avalid", bus.m_axi_avalid, 0);
      check("rst_wc_valid", bus.m_wc_valid, 0);
      check("rst_rc_valid", bus.m_rc_valid, 0);
      check("rst_aready", bus.s_axi_aready, 0);
      check("rst_stall", bus.stall, 0);
      check("rst_select", bus.m_select, 0);
      check("rst_region", bus.m_axi_aregion, 0);
      check("rst_decerr", bus.m_rc_decerr, 0);

      // Default map hit with latency checks
      start_req(8'd3, 32'h0100_0040, 3'b000, mk(2'd1, 4'd0, 1'b0));
      step(1);
      check("t1_avalid_n1", bus.m_axi_avalid, 1);
      step(1);
      check("t1_aready_n2", bus.s_axi_aready, 1);
      wait_accept("t1_accept");
      complete(8'd3);

      // Unmapped address, reply command held by rc_ready
      bus.m_rc_ready = 1'b0;
      start_req(8'd4, 32'h0400_0000, 3'b000, mk(2'd0, 4'd0, 1'b1));
      step(4);
      check("t2_rc_held", bus.m_rc_valid, 1);
      check("t2_no_fwd", bus.m_axi_avalid, 0);
      check("t2_aready_held", bus.s_axi_aready, 0);
      bus.m_rc_ready = 1'b1;
      wait_accept("t2_accept");

      // Secure master: non-secure access errors, secure access hits
      do_req(8'd4, 32'h0300_0010, 3'b010, mk(2'd0, 4'd0, 1'b1), "t3_ns_accept");
      do_req(8'd4, 32'h0300_0010, 3'b000, mk(2'd3, 4'd0, 1'b0), "t3_s_accept");
      complete(8'd4);
`ifdef AXI_XBAR_ADDR_DECERR_CNT_EN
      check("decerr_count", decerr_count, 2);
`endif

      // Per-master issue limit of 2 on master 0
      do_req(8'd1, 32'h0000_0000, 3'b000, mk(2'd0, 4'd0, 1'b0), "t4_a_accept");
      do_req(8'd1, 32'h0000_0000, 3'b000, mk(2'd0, 4'd0, 1'b0), "t4_b_accept");
      start_req(8'd1, 32'h0000_0000, 3'b000, mk(2'd0, 4'd0, 1'b0));
      step(3);
      check("t4_stall", bus.stall, 1);
      check("t4_no_aready", bus.s_axi_aready, 0);
      check("t4_no_fwd", bus.m_axi_avalid, 0);
      complete(8'd1);
      check("t4_stall_clear", bus.stall, 0);
      check("t4_admitted", bus.m_axi_avalid, 1);
      wait_accept("t4_c_accept");

      // Both threads busy (ids 1, 2): id 5 waits for a thread to free
      do_req(8'd2, 32'h0100_0000, 3'b000, mk(2'd1, 4'd0, 1'b0), "t5_id2_accept");
      start_req(8'd5, 32'h0200_0000, 3'b000, mk(2'd2, 4'd0, 1'b0));
      step(3);
      check("t5_stall", bus.stall, 1);
      check("t5_no_aready", bus.s_axi_aready, 0);
      complete(8'd2);
      wait_accept("t5_id5_accept");
      check("t5_stall_clear", bus.stall, 0);
      complete(8'd1);
      complete(8'd1);
      complete(8'd5);

      // Same ID to a different master waits for the first to drain
      do_req(8'd7, 32'h0000_0000, 3'b000, mk(2'd0, 4'd0, 1'b0), "t6_first_accept");
      start_req(8'd7, 32'h0200_0000, 3'b000, mk(2'd2, 4'd0, 1'b0));
      step(3);
      check("t6_stall", bus.stall, 1);
      check("t6_no_fwd", bus.m_axi_avalid, 0);
      step(2);
      check("t6_stall_hold", bus.stall, 1);
      complete(8'd7);
      wait_accept("t6_second_accept");
      complete(8'd7);

      // Asynchronous reset in the middle of DECODE
      bus.m_axi_aready = 1'b0;
      start_req(8'd9, 32'h0100_0040, 3'b000, mk(2'd1, 4'd0, 1'b0));
      step(1);
      check("t7_in_decode", bus.m_axi_avalid, 1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("t7_rst_avalid", bus.m_axi_avalid, 0);
      check("t7_rst_wc_valid", bus.m_wc_valid, 0);
      check("t7_rst_rc_valid", bus.m_rc_valid, 0);
      check("t7_rst_aready", bus.s_axi_aready, 0);
      check("t7_rst_stall", bus.stall, 0);
      bus.s_axi_avalid = 1'b0;
      bus.m_axi_aready = 1'b1;
      step(2);
      @(negedge clk) rst_n = 1'b1;
      step(1);
      check("t7_rel_select", bus.m_select, 0);
      check("t7_rel_decerr", bus.m_wc_decerr, 0);
      // Cleared thread state lets id 9 go to another master
      do_req(8'd9, 32'h0200_0000, 3'b000, mk(2'd2, 4'd0, 1'b0), "t7_after_reset_accept");
      complete(8'd9);
      step(2);

      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
